// File: rtl/ui_pkg.sv
// Shared types and default constants for the button conditioner.
package ui_pkg;

   // Per-channel auto-repeat controller states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rep_state_t;

   localparam int unsigned DEF_NUM_CH             = 5;
   localparam int unsigned DEF_LOG_DEBOUNCE_COUNT = 20;
   localparam int unsigned DEF_LOG_DELAY_COUNT    = 25;
   localparam int unsigned DEF_LOG_REPEAT_COUNT   = 22;

   // Larger of two widths, used to size the shared delay/repeat counter
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debouncer, edge pulses and auto-repeat FSM.
module btn_channel
   import ui_pkg::*;
#(
   parameter int unsigned LOG_DEBOUNCE_COUNT = DEF_LOG_DEBOUNCE_COUNT,
   parameter int unsigned LOG_DELAY_COUNT    = DEF_LOG_DELAY_COUNT,
   parameter int unsigned LOG_REPEAT_COUNT   = DEF_LOG_REPEAT_COUNT
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic raw_in,
   input  logic repeat_en_in,
   output logic level_out,
   output logic press_out,
   output logic release_out,
   output logic move_out,
   output logic hold_out
);

   localparam int unsigned DBW = LOG_DEBOUNCE_COUNT;
   localparam int unsigned CW  = max_u(LOG_DELAY_COUNT, LOG_REPEAT_COUNT);

   localparam logic [DBW-1:0] DB_LAST = DBW'((64'd1 << LOG_DEBOUNCE_COUNT) - 64'd1);
   localparam logic [CW-1:0]  DL_LAST = CW'((64'd1 << LOG_DELAY_COUNT) - 64'd1);
   localparam logic [CW-1:0]  RP_LAST = CW'((64'd1 << LOG_REPEAT_COUNT) - 64'd1);

   logic           sync_q1;
   logic           sync_q2;
   logic [DBW-1:0] db_cnt_q;
   logic           level_q;
   logic           level_d_q;
   logic           press_q;
   logic           release_q;

   rep_state_t     state_q;
   rep_state_t     state_nxt;
   logic [CW-1:0]  rcnt_q;
   logic [CW-1:0]  rcnt_nxt;
   logic           move_q;
   logic           move_nxt;
   logic           hold_q;
   logic           hold_nxt;

   logic           level_rise;

   assign level_rise = level_q & ~level_d_q;

   // Two-flop synchroniser for the asynchronous raw level
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= raw_in;
         sync_q2 <= sync_q1;
      end
   end

   // Debounce: accept a new level only after it has disagreed for the whole window
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         db_cnt_q <= '0;
         level_q  <= 1'b0;
      end else if (sync_q2 != level_q) begin
         if (db_cnt_q == DB_LAST) begin
            level_q  <= sync_q2;
            db_cnt_q <= '0;
         end else begin
            db_cnt_q <= db_cnt_q + DBW'(1);
         end
      end else begin
         db_cnt_q <= '0;
      end
   end

   // One-cycle press/release pulses in the cycle after the debounced edge
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         level_d_q <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         level_d_q <= level_q;
         press_q   <= level_q & ~level_d_q;
         release_q <= ~level_q & level_d_q;
      end
   end

   // Repeat FSM state, counter and registered move/hold outputs
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
         rcnt_q  <= '0;
         move_q  <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         rcnt_q  <= rcnt_nxt;
         move_q  <= move_nxt;
         hold_q  <= hold_nxt;
      end
   end

   // Next state and counter: a debounced release always returns to IDLE
   always_comb begin
      state_nxt = state_q;
      rcnt_nxt  = rcnt_q;
      case (state_q)
         IDLE: begin
            if (level_rise) begin
               state_nxt = DELAY;
               rcnt_nxt  = '0;
            end
         end
         DELAY: begin
            if (!level_q) begin
               state_nxt = IDLE;
               rcnt_nxt  = '0;
            end else if (rcnt_q == DL_LAST) begin
               state_nxt = REPEAT;
               rcnt_nxt  = '0;
            end else begin
               rcnt_nxt = rcnt_q + CW'(1);
            end
         end
         REPEAT: begin
            if (!level_q) begin
               state_nxt = IDLE;
               rcnt_nxt  = '0;
            end else if (rcnt_q == RP_LAST) begin
               rcnt_nxt = '0;
            end else begin
               rcnt_nxt = rcnt_q + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            rcnt_nxt  = '0;
         end
      endcase
   end

   // Move pulse on press, delay expiry and each repeat wrap; never back-to-back
   always_comb begin
      move_nxt = 1'b0;
      case (state_q)
         IDLE:    move_nxt = level_rise;
         DELAY:   move_nxt = level_q && (rcnt_q == DL_LAST) && repeat_en_in;
         REPEAT:  move_nxt = level_q && (rcnt_q == RP_LAST) && repeat_en_in;
         default: move_nxt = 1'b0;
      endcase
      move_nxt = move_nxt & ~move_q;
      hold_nxt = (state_nxt == REPEAT);
   end

   assign level_out   = level_q;
   assign press_out   = press_q;
   assign release_out = release_q;
   assign move_out    = move_q;
   assign hold_out    = hold_q;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: one independent btn_channel per input.
module btn_conditioner
   import ui_pkg::*;
#(
   parameter int unsigned NUM_CH             = DEF_NUM_CH,
   parameter int unsigned LOG_DEBOUNCE_COUNT = DEF_LOG_DEBOUNCE_COUNT,
   parameter int unsigned LOG_DELAY_COUNT    = DEF_LOG_DELAY_COUNT,
   parameter int unsigned LOG_REPEAT_COUNT   = DEF_LOG_REPEAT_COUNT
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic [NUM_CH-1:0] raw_in,
   input  logic [NUM_CH-1:0] repeat_en_in,
   output logic [NUM_CH-1:0] level_out,
   output logic [NUM_CH-1:0] press_out,
   output logic [NUM_CH-1:0] release_out,
   output logic [NUM_CH-1:0] move_out,
   output logic [NUM_CH-1:0] hold_out
);

   // Replicate the channel logic; channels share only clock and reset
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      btn_channel #(
         .LOG_DEBOUNCE_COUNT (LOG_DEBOUNCE_COUNT),
         .LOG_DELAY_COUNT    (LOG_DELAY_COUNT),
         .LOG_REPEAT_COUNT   (LOG_REPEAT_COUNT)
      ) u_ch (
         .clk_in       (clk_in),
         .rst_n_in     (rst_n_in),
         .raw_in       (raw_in[g]),
         .repeat_en_in (repeat_en_in[g]),
         .level_out    (level_out[g]),
         .press_out    (press_out[g]),
         .release_out  (release_out[g]),
         .move_out     (move_out[g]),
         .hold_out     (hold_out[g])
      );
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench: stimulus queues expected output events, a monitor matches them.
module tb_btn_conditioner;

   localparam int N_DB = 4;
   localparam int N_DL = 8;
   localparam int N_RP = 4;
   localparam int NO_CUT = 1 << 30;

   localparam int K_LR   = 0;
   localparam int K_LF   = 1;
   localparam int K_PRS  = 2;
   localparam int K_REL  = 3;
   localparam int K_MOVE = 4;
   localparam int K_HR   = 5;
   localparam int K_HF   = 6;

   typedef struct {
      int cyc;
      int ch;
      int kind;
   } ev_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] raw;
   logic [3:0] en;
   logic [3:0] level;
   logic [3:0] press;
   logic [3:0] rel;
   logic [3:0] move;
   logic [3:0] hold;

   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;
   ev_t  exp_q[$];
   logic [3:0] prev_level = '0;
   logic [3:0] prev_hold  = '0;

   btn_conditioner #(
      .NUM_CH             (4),
      .LOG_DEBOUNCE_COUNT (2),
      .LOG_DELAY_COUNT    (3),
      .LOG_REPEAT_COUNT   (2)
   ) dut (
      .clk_in       (clk),
      .rst_n_in     (rst_n),
      .raw_in       (raw),
      .repeat_en_in (en),
      .level_out    (level),
      .press_out    (press),
      .release_out  (rel),
      .move_out     (move),
      .hold_out     (hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(input int k);
      case (k)
         K_LR:    return "level_rise";
         K_LF:    return "level_fall";
         K_PRS:   return "press";
         K_REL:   return "release";
         K_MOVE:  return "move";
         K_HR:    return "hold_rise";
         default: return "hold_fall";
      endcase
   endfunction

   task automatic push(input int ch, input int kind, input int c, input int cut);
      ev_t e;
      if (c <= cut) begin
         e.cyc = c; e.ch = ch; e.kind = kind;
         exp_q.push_back(e);
      end
   endtask

   // Expected events for raw high first sampled at edge t0, held for h edges
   task automatic model_push(input int ch, input int t0, input int h, input logic rep_en, input int cut);
      int lr, lf, er;
      lr = t0 + N_DB + 1;
      lf = t0 + h + N_DB + 1;
      er = lr + 1 + N_DL;
      push(ch, K_LR, lr, cut);
      push(ch, K_PRS, lr + 1, cut);
      push(ch, K_MOVE, lr + 1, cut);
      if (er <= lf) begin
         push(ch, K_HR, er, cut);
         if (rep_en) push(ch, K_MOVE, er, cut);
         for (int e = er + N_RP; e <= lf; e += N_RP)
            if (rep_en) push(ch, K_MOVE, e, cut);
         push(ch, K_HF, lf + 1, cut);
      end
      push(ch, K_LF, lf, cut);
      push(ch, K_REL, lf + 1, cut);
   endtask

   task automatic check_ev(input int ch, input int kind);
      int idx;
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i].ch == ch && exp_q[i].kind == kind) begin
            idx = i;
            break;
         end
      end
      tests++;
      if (idx < 0) begin
         fails++;
         $display("FAIL %s ch%0d: got event at cycle %0d, expected none", kname(kind), ch, cyc);
      end else begin
         if (exp_q[idx].cyc != cyc) begin
            fails++;
            $display("FAIL %s ch%0d: got cycle %0d, expected cycle %0d", kname(kind), ch, cyc, exp_q[idx].cyc);
         end
         exp_q.delete(idx);
      end
   endtask

   // Monitor: outputs zero under reset, otherwise match each observed event
   always @(negedge clk) begin
      if (!rst_n) begin
         tests++;
         if ({level, press, rel, move, hold} != 20'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %05h, expected 00000", {level, press, rel, move, hold});
         end
         prev_level = '0;
         prev_hold  = '0;
      end else begin
         for (int ch = 0; ch < 4; ch++) begin
            if (level[ch] && !prev_level[ch]) check_ev(ch, K_LR);
            if (!level[ch] && prev_level[ch]) check_ev(ch, K_LF);
            if (press[ch]) check_ev(ch, K_PRS);
            if (rel[ch])   check_ev(ch, K_REL);
            if (move[ch])  check_ev(ch, K_MOVE);
            if (hold[ch] && !prev_hold[ch]) check_ev(ch, K_HR);
            if (!hold[ch] && prev_hold[ch]) check_ev(ch, K_HF);
         end
         prev_level = level;
         prev_hold  = hold;
      end
   end

   task automatic press_multi(input logic [3:0] mask, input int h);
      int t0;
      @(posedge clk); #1;
      t0 = cyc + 1;
      for (int ch = 0; ch < 4; ch++)
         if (mask[ch]) model_push(ch, t0, h, en[ch], NO_CUT);
      raw = raw | mask;
      repeat (h) @(posedge clk);
      #1;
      raw = raw & ~mask;
   endtask

   initial begin
      int t0;
      int tr;
      rst_n = 1'b0;
      raw   = '0;
      en    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // Clean short press on ch0, released before the delay expires
      en = 4'b0001;
      press_multi(4'b0001, 6);
      repeat (20) @(posedge clk);

      // Glitch train on ch1: 3 high, 1 low, never long enough to debounce
      @(posedge clk); #1;
      repeat (4) begin
         raw[1] = 1'b1;
         repeat (3) @(posedge clk);
         #1 raw[1] = 1'b0;
         @(posedge clk); #1;
      end
      repeat (12) @(posedge clk);
      @(negedge clk);
      tests++;
      if (level[1] !== 1'b0) begin
         fails++;
         $display("FAIL glitch_level ch1: got %b, expected 0", level[1]);
      end

      // Auto-repeat on ch2
      en = 4'b0100;
      press_multi(4'b0100, 40);
      repeat (20) @(posedge clk);

      // Repeat disabled on ch3: single move, hold still rises
      en = 4'b0000;
      press_multi(4'b1000, 40);
      repeat (20) @(posedge clk);

      // Reset while ch2 is repeating and ch0 is held
      en = 4'b0100;
      @(posedge clk); #1;
      t0 = cyc + 1;
      model_push(0, t0, 1000, en[0], t0 + 19);
      model_push(2, t0, 1000, en[2], t0 + 19);
      raw = 4'b0101;
      repeat (21) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      tests++;
      if ({level, press, rel, move, hold} != 20'd0) begin
         fails++;
         $display("FAIL async_reset: got %05h, expected 00000", {level, press, rel, move, hold});
      end
      raw[2] = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      tr = cyc + 1;
      model_push(0, tr, 10, en[0], NO_CUT);
      repeat (10) @(posedge clk);
      #1 raw[0] = 1'b0;
      repeat (30) @(posedge clk);

      // All channels pressed together with mixed repeat enables
      en = 4'b0101;
      press_multi(4'b1111, 30);
      repeat (25) @(posedge clk);

      @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL pending_events: got %0d outstanding, expected 0", exp_q.size());
         foreach (exp_q[i])
            $display("  outstanding %s ch%0d at cycle %0d", kname(exp_q[i].kind), exp_q[i].ch, exp_q[i].cyc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
